// File: rtl/button_event.sv
// button_event: turns debounced mode/add/sub levels into one-clock command pulses.
// Add and sub each get a hold-to-repeat lane; pressing both together locks both
// lanes until each button is released. Mode is a plain press pulse unless
// MODE_LONG_PRESS_EN is defined, which enables short/long press discrimination.

// One add/sub lane: press pulse, hold delay, periodic repeat, conflict lockout.
module button_rpt_lane #(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clock,
  input  logic reset,
  input  logic own_i,
  input  logic other_i,
  output logic pulse_o
);
  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pulse_n;

  // State, counter and registered pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse_o <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pulse_o <= pulse_n;
    end
  end

  // Next state; a simultaneous add+sub press overrides everything else.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pulse_n = 1'b0;
    if (own_i && other_i) begin
      state_n = LOCK;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: if (own_i) begin
          state_n = HOLD;
          cnt_n   = '0;
          pulse_n = 1'b1;
        end
        HOLD: if (!own_i) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state_n = REPEAT;
          cnt_n   = '0;
          pulse_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        REPEAT: if (!own_i) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CW'(REPEAT_CYCLES - 1)) begin
          cnt_n   = '0;
          pulse_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        LOCK: if (!own_i) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end
endmodule

// Top: two repeat lanes (0 = add, 1 = sub) plus the mode handler.
module button_event #(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int LONG_CYCLES   = 200000000
) (
  input  logic clock,
  input  logic reset,
  input  logic mode_i,
  input  logic add_i,
  input  logic sub_i,
  output logic mode_o,
  output logic mode_long_o,
  output logic add_o,
  output logic sub_o
);
  localparam int NUM_LANES = 2;

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_param
    $error("button_event: cycle parameters must be >= 2");
  end

  logic [NUM_LANES-1:0] btn, pulse;
  assign btn = {sub_i, add_i};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    button_rpt_lane #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_lane (
      .clock  (clock),
      .reset  (reset),
      .own_i  (btn[i]),
      .other_i(btn[NUM_LANES-1-i]),
      .pulse_o(pulse[i])
    );
  end

  assign add_o = pulse[0];
  assign sub_o = pulse[1];

`ifdef MODE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES);
  typedef enum logic [1:0] {M_IDLE, M_TIMING, M_DONE} mstate_t;

  mstate_t       mstate, mstate_n;
  logic [LW-1:0] mcnt, mcnt_n;
  logic          mode_n, long_n;

  // Mode state, counter and registered pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mstate      <= M_IDLE;
      mcnt        <= '0;
      mode_o      <= 1'b0;
      mode_long_o <= 1'b0;
    end else begin
      mstate      <= mstate_n;
      mcnt        <= mcnt_n;
      mode_o      <= mode_n;
      mode_long_o <= long_n;
    end
  end

  // Press edge counts as the first held clock, so the long pulse lands
  // LONG_CYCLES-1 edges after the press.
  always_comb begin
    mstate_n = mstate;
    mcnt_n   = mcnt;
    mode_n   = 1'b0;
    long_n   = 1'b0;
    case (mstate)
      M_IDLE: if (mode_i) begin
        mstate_n = M_TIMING;
        mcnt_n   = LW'(1);
      end
      M_TIMING: if (!mode_i) begin
        mstate_n = M_IDLE;
        mcnt_n   = '0;
        mode_n   = 1'b1;
      end else if (mcnt == LW'(LONG_CYCLES - 1)) begin
        mstate_n = M_DONE;
        mcnt_n   = '0;
        long_n   = 1'b1;
      end else begin
        mcnt_n = mcnt + 1'b1;
      end
      M_DONE: if (!mode_i) mstate_n = M_IDLE;
      default: begin
        mstate_n = M_IDLE;
        mcnt_n   = '0;
      end
    endcase
  end
`else
  typedef enum logic {M_IDLE, M_HELD} mstate_t;

  mstate_t mstate, mstate_n;
  logic    mode_n;

  // Mode state and registered press pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mstate <= M_IDLE;
      mode_o <= 1'b0;
    end else begin
      mstate <= mstate_n;
      mode_o <= mode_n;
    end
  end

  // Pulse once on press, then wait for release.
  always_comb begin
    mstate_n = mstate;
    mode_n   = 1'b0;
    case (mstate)
      M_IDLE: if (mode_i) begin
        mstate_n = M_HELD;
        mode_n   = 1'b1;
      end
      M_HELD:  if (!mode_i) mstate_n = M_IDLE;
      default: mstate_n = M_IDLE;
    endcase
  end

  assign mode_long_o = 1'b0;
`endif
endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: each scenario pushes the cycle and value of
// every pulse it expects; a negedge monitor pops and compares as pulses appear.
module tb_button_event;
  localparam int HOLD = 8, RPT = 4, LONGC = 16;
  localparam logic [3:0] SUB = 4'b0001, ADD = 4'b0010, MODE = 4'b0100, LNG = 4'b1000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mode_i = 1'b0, add_i = 1'b0, sub_i = 1'b0;
  logic mode_o, mode_long_o, add_o, sub_o;

  typedef struct {int cyc; logic [3:0] outs;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [3:0] obs;
  int cyc = 0;
  int errors = 0, checks = 0;
  bit mon_en = 1'b0;

  button_event #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT), .LONG_CYCLES(LONGC)) dut (
    .clock(clock), .reset(reset), .mode_i(mode_i), .add_i(add_i), .sub_i(sub_i),
    .mode_o(mode_o), .mode_long_o(mode_long_o), .add_o(add_o), .sub_o(sub_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: any pulse must match the scoreboard head; an overdue head is a miss.
  always @(negedge clock) begin
    if (mon_en) begin
      obs = {mode_long_o, mode_o, add_o, sub_o};
      if (obs !== 4'b0000) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", cyc, obs);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc || e.outs !== obs) begin
            errors++;
            $display("FAIL pulse cyc=%0d got=%b want=%b@%0d", cyc, obs, e.outs, e.cyc);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse cyc=%0d got=0000 want=%b@%0d", cyc, sb[0].outs, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  function automatic void push(int c, logic [3:0] o);
    exp_t x;
    x.cyc = c;
    x.outs = o;
    sb.push_back(x);
  endfunction

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mode_long_o, mode_o, add_o, sub_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0000", {mode_long_o, mode_o, add_o, sub_o});
    end
    mon_en = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_tap();
    int k;
    @(negedge clock);
    add_i = 1'b1;
    k = cyc + 1;
    push(k, ADD);
    repeat (3) @(negedge clock);
    add_i = 1'b0;
    repeat (12) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL tap_drain left=%0d want=0", sb.size());
    end
  endtask

  task automatic test_hold();
    int k;
    @(negedge clock);
    add_i = 1'b1;
    k = cyc + 1;
    push(k, ADD); push(k + 8, ADD); push(k + 12, ADD); push(k + 16, ADD); push(k + 20, ADD);
    repeat (21) @(negedge clock);
    add_i = 1'b0;
    repeat (12) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL hold_drain left=%0d want=0", sb.size());
    end
  endtask

  task automatic test_conflict();
    int k, p;
    @(negedge clock);
    sub_i = 1'b1;
    k = cyc + 1;
    push(k, SUB);
    repeat (5) @(negedge clock);
    add_i = 1'b1;
    repeat (4) @(negedge clock);
    // mode is independent of the add/sub lockout
    mode_i = 1'b1;
    p = cyc + 1;
`ifdef MODE_LONG_PRESS_EN
    push(p + 1, MODE);
`else
    push(p, MODE);
`endif
    @(negedge clock);
    mode_i = 1'b0;
    repeat (10) @(negedge clock);
    sub_i = 1'b0;
    repeat (14) @(negedge clock);
    add_i = 1'b0;
    repeat (2) @(negedge clock);
    add_i = 1'b1;
    push(cyc + 1, ADD);
    repeat (2) @(negedge clock);
    add_i = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL conflict_drain left=%0d want=0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clock);
    add_i = 1'b1;
    k = cyc + 1;
    push(k, ADD);
    @(negedge clock);
    add_i = 1'b0;
    sub_i = 1'b1;
    push(k + 1, SUB);
    @(negedge clock);
    sub_i = 1'b0;
    repeat (6) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL b2b_drain left=%0d want=0", sb.size());
    end
  endtask

  task automatic test_reset_mid_repeat();
    int k;
    @(negedge clock);
    add_i = 1'b1;
    k = cyc + 1;
    push(k, ADD); push(k + 8, ADD); push(k + 12, ADD);
    repeat (17) @(posedge clock);
    #1;
    checks++;
    if (add_o !== 1'b1 || cyc !== k + 16) begin
      errors++;
      $display("FAIL repeat_before_reset got=%b@%0d want=1@%0d", add_o, cyc, k + 16);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({mode_long_o, mode_o, add_o, sub_o} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got=%b want=0000", {mode_long_o, mode_o, add_o, sub_o});
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    push(cyc + 1, ADD);
    repeat (3) @(negedge clock);
    add_i = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL reset_drain left=%0d want=0", sb.size());
    end
  endtask

  task automatic test_release_coincide();
    int k;
    @(negedge clock);
    add_i = 1'b1;
    k = cyc + 1;
    push(k, ADD);
    repeat (8) @(negedge clock);
    add_i = 1'b0;
    @(negedge clock);
    add_i = 1'b1;
    push(k + 9, ADD);
    @(negedge clock);
    add_i = 1'b0;
    repeat (12) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL coincide_drain left=%0d want=0", sb.size());
    end
  endtask

  task automatic test_mode();
    int k;
    @(negedge clock);
    mode_i = 1'b1;
    k = cyc + 1;
`ifdef MODE_LONG_PRESS_EN
    push(k + 5, MODE);
`else
    push(k, MODE);
`endif
    repeat (5) @(negedge clock);
    mode_i = 1'b0;
    repeat (4) @(negedge clock);
    mode_i = 1'b1;
    k = cyc + 1;
`ifdef MODE_LONG_PRESS_EN
    push(k + LONGC - 1, LNG);
`else
    push(k, MODE);
`endif
    repeat (30) @(negedge clock);
    mode_i = 1'b0;
    repeat (6) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL mode_drain left=%0d want=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold();
    test_conflict();
    test_back_to_back();
    test_reset_mid_repeat();
    test_release_coincide();
    test_mode();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d want=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/button_event.md
# button_event

Converts the three debounced push-button levels into single-cycle command pulses for the watch interface. It sits between the debounce instances and the watch interface, and provides:
- press detection on each button;
- hold-to-repeat on the add and sub buttons, for fast time setting;
- add/sub conflict lockout.

All outputs are registered pulses, one clock wide.

## Interface
Parameters:
- HOLD_CYCLES, 50000000: clocks from first add/sub pulse to first repeat pulse; must be ≥ 2.
- REPEAT_CYCLES, 10000000: clocks between repeat pulses; must be ≥ 2.
- LONG_CYCLES, 200000000: mode hold time that qualifies as a long press; must be ≥ 2. Used only with MODE_LONG_PRESS_EN.

Ports:
- clock, input, 1: system clock (100 MHz).
- reset, input, 1: reset; asynchronous, active-low.
- mode_i, input, 1: debounced mode level, high = pressed.
- add_i, input, 1: debounced add level.
- sub_i, input, 1: debounced sub level.
- mode_o, output, 1: mode pulse.
- mode_long_o, output, 1: mode long-press pulse.
- add_o, output, 1: add step pulse.
- sub_o, output, 1: sub step pulse.

## Operation
- Inputs are already synchronous to clock; no internal synchronizer is used.
- Add and sub each run an independent FSM with one counter each. Counter width is $clog2 of max(HOLD_CYCLES, REPEAT_CYCLES).
- FSM states:
  - IDLE:
    - own input = 1 and other input = 0: go to HOLD, clear counter, assert pulse.
    - own input = 1 and other input = 1: go to LOCK, no pulse.
  - HOLD: counter increments each clock.
    - Counter = HOLD_CYCLES-1: go to REPEAT, clear counter, assert pulse.
  - REPEAT: counter increments each clock.
    - Counter = REPEAT_CYCLES-1: clear counter, assert pulse, stay in REPEAT.
  - LOCK: no pulses. Go to IDLE only when own input = 0.
- Release: in HOLD or REPEAT, own input = 0 → IDLE. No pulse is emitted on that edge.
- Conflict: in any state, add_i = 1 and sub_i = 1 on the same edge → both FSMs go to LOCK. No add_o or sub_o pulse is emitted on that edge. This takes priority over every other transition.
- add_o and sub_o are never high in the same cycle.
- Mode handling is described under Configuration. Mode does not auto-repeat and is unaffected by add/sub lockout.
- Reset (async assert):
  - all FSMs go to IDLE;
  - counters go to 0;
  - all outputs go to 0 immediately.
- A button held through reset release is treated as a new press on the first sampled edge.

## Timing
- Latency:
  - Rising level sampled at edge k → pulse high between edges k and k+1.
  - Each pulse is exactly one cycle wide.
- Add/sub pulse train while held from edge k:
  - pulses at edges k, k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, k+HOLD_CYCLES+2·REPEAT_CYCLES, and so on.
- Release sampled on the same edge a pulse would fire: release wins, no pulse.
- Counters never wrap: they clear when a pulse fires or the FSM leaves its state.
- Outputs are 0 while reset is low, then update only on clock rising edges.

## Configuration
- Macro: MODE_LONG_PRESS_EN.
- Defined:
  - Mode FSM states are IDLE, TIMING and DONE. The mode counter is sized for LONG_CYCLES.
  - Press → TIMING; the counter increments each clock.
  - Release in TIMING before the counter reaches LONG_CYCLES-1 → mode_o pulse on the release edge, then IDLE.
  - Counter = LONG_CYCLES-1 while still held → mode_long_o pulse, go to DONE.
  - Release in DONE → IDLE with no pulse.
- Undefined:
  - mode_o pulses on the sampled press edge, latency 1, the same as add.
  - The mode FSM stays idle until release; no timing counter exists.
  - mode_long_o is tied to 0.

## Test plan
Benches use HOLD_CYCLES = 8, REPEAT_CYCLES = 4, LONG_CYCLES = 16.
1. Tap: add_i high for 3 clocks → one add_o pulse, one cycle after the rise; sub_o stays 0.
2. Hold: add_i high for 20 clocks from edge k → add_o pulses at k, k+8, k+12, k+16, k+20; none after release.
3. Conflict: sub_i held, add_i rises at k+5 → sub_o pulses only at k; no further add_o/sub_o pulses while both are high. Sub released while add is held → still no add_o until add_i falls and rises again.
4. Reset mid-repeat: assert reset during REPEAT → all outputs 0 asynchronously. Release reset with add_i = 1 → add_o pulse one cycle after the first sampled edge.
5. Mode short/long, with MODE_LONG_PRESS_EN:
   - hold 5 clocks → one mode_o pulse on release;
   - hold 30 clocks → one mode_long_o pulse at edge k+15 and no mode_o pulse.
   - Without the macro: mode_o pulses one cycle after the rise and mode_long_o is always 0.
6. Release coincidence: add_i falls on the same sampled edge as the k+8 repeat → no pulse at k+8; FSM returns to IDLE.
